alu_operand_stage: RTL and testbench
====================================

Name: alu_operand_stage

Overview:
- ID/EX pipeline stage that feeds the ALU.
- Registers the decoded instruction, PC and register-file read data on each clock.
- Decodes the 4-bit ALU opcode, generates the immediate and selects the ALU operands alu_a and alu_b.
- Optionally forwards the writeback result into the operands.

Parameters:
RESET_PC, 32'h0000_0000, ex_pc value after reset
NOP_INST, 32'h0000_0013, instruction held on reset or flush (addi x0,x0,0)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
id_inst  in  32  instruction in decode
id_pc  in  32  PC of id_inst
id_rd1  in  32  regfile read data for id_inst[19:15]
id_rd2  in  32  regfile read data for id_inst[24:20]
stall  in  1  hold stage contents
flush  in  1  replace stage contents with bubble
wb_we  in  1  writeback write enable
wb_rd  in  5  writeback destination register
wb_data  in  32  writeback data
alu_a  out  32  ALU operand A
alu_b  out  32  ALU operand B
alu_sel  out  4  ALU opcode
ex_inst  out  32  registered instruction
ex_pc  out  32  registered PC
ex_rs2_data  out  32  forwarded rs2 value (store data)
ex_valid  out  1  stage holds a real instruction

Behaviour:
- Clock and reset: one clock (clk); reset (rst) is synchronous and active-high.
- Reset values: ex_inst=NOP_INST, ex_pc=RESET_PC, captured rd1/rd2=0, alu_sel=0, ex_valid=0.
- Reset is sampled at the clock edge and overrides stall and flush.
- Reset mid-operation discards the held instruction.
- Priority each edge: rst > flush > stall > capture.
  - flush: load bubble (NOP_INST, valid=0, alu_sel=0). PC is captured from id_pc.
  - stall: all fields hold.
  - otherwise: capture id_* with valid=1, plus the decoded alu_sel and operand selects.
- Latency: one cycle from id_* to alu_sel/alu_a/alu_b.
- alu_a/alu_b are combinational from registered fields through the forwarding mux.
- alu_sel encoding: ADD=0, SUB=1, SLL=2, SLT=3, SLTU=4, XOR=5, SRL=6, SRA=7, OR=8, AND=9.
- OP (0110011), funct3 to alu_sel:
  - 0: SUB if inst[30], else ADD
  - 1: SLL; 2: SLT; 3: SLTU; 4: XOR
  - 5: SRA if inst[30], else SRL
  - 6: OR; 7: AND
- OP-IMM (0010011): same mapping, except funct3=0 is always ADD. inst[30] selects SRA/SRL only.
- All other opcodes use ADD: LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC. Unknown opcodes also use ADD.
- Operand A:
  - rs1 for OP, OP-IMM, LOAD, STORE, JALR
  - PC for BRANCH, JAL, AUIPC
  - 0 for LUI
- Operand B: rs2 for OP; imm otherwise.
- Immediate formats: I, S, B, U, J, all sign-extended per the ISA.
- Shift width rule:
  - When alu_sel ∈ {SLL, SRL, SRA}, alu_b = {27'b0, B[4:0]}.
  - This covers both the I-type shamt and R-type rs2.
  - It guarantees a shift amount < 32 and strips inst[30] from the SRAI immediate.
- x0: captured rs1/rs2 values are used as given. The register file returns 0 for x0.

Optional Feature:
- Macro: ALU_OPERAND_STAGE_FWD_EN.
- Defined:
  - If wb_we && wb_rd!=0 && wb_rd==ex_inst[19:15], the rs1 value is replaced by wb_data. rs2 uses ex_inst[24:20] the same way.
  - Forwarding applies before operand and shift-mask selection, and also drives ex_rs2_data.
  - While stall=1 and a forward matches, the captured rd1/rd2 register is updated with wb_data. The held instruction therefore keeps the value after writeback retires.
- Undefined:
  - No forward mux and no stall refresh.
  - alu_a/alu_b and ex_rs2_data come from the captured values only.
  - The hazard unit must stall through RAW hazards.

Decomposition:
- Shared package alu_pkg:
  - ALU_ADD..ALU_AND constants (4-bit)
  - opcode constants OPC_OP, OPC_OP_IMM, OPC_LOAD, OPC_STORE, OPC_BRANCH, OPC_JAL, OPC_JALR, OPC_LUI, OPC_AUIPC
  - A_SEL_RS1/PC/ZERO and B_SEL_RS2/IMM encodings
  - NOP constant
- The alu module also uses alu_pkg.
- Sub-module imm_gen: combinational, inst[31:0] to imm[31:0], instantiated once.

Test Plan:
1. Reset: rst=1 for 2 cycles, then release with stall=0 → ex_valid=0, ex_inst=0x00000013, alu_sel=0 before the first capture.
2. R-type SUB (0x402080B3), id_rd1=10, id_rd2=3 → next cycle alu_a=10, alu_b=3, alu_sel=1, ex_valid=1.
3. SRAI x5,x6,4 (0x40435293), id_rd1=0x80000000 → alu_sel=7, alu_b=4. An R-type SLL with rs2=0x00000023 → alu_b=3.
4. LUI (0x123450B7) → alu_a=0, alu_b=0x12345000, alu_sel=0. BEQ at id_pc=0x1000 with imm=+8 → alu_a=0x1000, alu_b=8.
5. Forwarding (FWD_EN):
   - ADD x3,x1,x2 captured with rd1=5; wb_we=1, wb_rd=1, wb_data=0x100 → alu_a=0x100.
   - wb_rd=0 → alu_a=5.
   - Hold stall=1 through the WB pulse, then deassert WB → alu_a remains 0x100.
6. stall=1 and flush=1 in the same cycle → ex_valid=0, ex_inst=0x00000013. stall alone for 3 cycles → ex_inst and ex_pc unchanged while id_* changes.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: ALU opcodes, RV32 major opcodes, operand selects and decode helpers
package alu_pkg;
    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_SLL  = 4'd2;
    localparam logic [3:0] ALU_SLT  = 4'd3;
    localparam logic [3:0] ALU_SLTU = 4'd4;
    localparam logic [3:0] ALU_XOR  = 4'd5;
    localparam logic [3:0] ALU_SRL  = 4'd6;
    localparam logic [3:0] ALU_SRA  = 4'd7;
    localparam logic [3:0] ALU_OR   = 4'd8;
    localparam logic [3:0] ALU_AND  = 4'd9;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {A_SEL_RS1, A_SEL_PC, A_SEL_ZERO} a_sel_e;
    typedef enum logic {B_SEL_RS2, B_SEL_IMM} b_sel_e;

    function automatic logic [3:0] decode_alu_sel(input logic [31:0] inst);
        logic is_op;
        logic [3:0] sel;
        is_op = inst[6:0] == OPC_OP;
        case (inst[14:12])
            3'd0:    sel = (is_op && inst[30]) ? ALU_SUB : ALU_ADD;
            3'd1:    sel = ALU_SLL;
            3'd2:    sel = ALU_SLT;
            3'd3:    sel = ALU_SLTU;
            3'd4:    sel = ALU_XOR;
            3'd5:    sel = inst[30] ? ALU_SRA : ALU_SRL;
            3'd6:    sel = ALU_OR;
            default: sel = ALU_AND;
        endcase
        return (is_op || inst[6:0] == OPC_OP_IMM) ? sel : ALU_ADD;
    endfunction

    function automatic a_sel_e decode_a_sel(input logic [6:0] opc);
        return (opc == OPC_BRANCH || opc == OPC_JAL || opc == OPC_AUIPC) ? A_SEL_PC :
               (opc == OPC_LUI) ? A_SEL_ZERO : A_SEL_RS1;
    endfunction

    function automatic b_sel_e decode_b_sel(input logic [6:0] opc);
        return (opc == OPC_OP) ? B_SEL_RS2 : B_SEL_IMM;
    endfunction
endpackage

// File: rtl/imm_gen.sv
// imm_gen: sign-extended I/S/B/U/J immediate selected by the major opcode
module imm_gen
    import alu_pkg::*;
(
    input  logic [31:0] inst,
    output logic [31:0] imm
);
    logic [6:0]  opc;
    logic [31:0] i_imm, s_imm, b_imm, u_imm, j_imm;

    always_comb begin
        opc   = inst[6:0];
        i_imm = {{20{inst[31]}}, inst[31:20]};
        s_imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
        b_imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
        u_imm = {inst[31:12], 12'b0};
        j_imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
        imm   = (opc == OPC_STORE)  ? s_imm :
                (opc == OPC_BRANCH) ? b_imm :
                (opc == OPC_LUI || opc == OPC_AUIPC) ? u_imm :
                (opc == OPC_JAL)    ? j_imm : i_imm;
    end
endmodule

// File: rtl/alu_operand_stage.sv
// alu_operand_stage: ID/EX register feeding the ALU with decoded opcode and operands.
// Define ALU_OPERAND_STAGE_FWD_EN to forward the writeback result into rs1/rs2.
module alu_operand_stage
    import alu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] id_inst,
    input  logic [31:0] id_pc,
    input  logic [31:0] id_rd1,
    input  logic [31:0] id_rd2,
    input  logic        stall,
    input  logic        flush,
    input  logic        wb_we,
    input  logic [4:0]  wb_rd,
    input  logic [31:0] wb_data,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [3:0]  alu_sel,
    output logic [31:0] ex_inst,
    output logic [31:0] ex_pc,
    output logic [31:0] ex_rs2_data,
    output logic        ex_valid
);
    logic [31:0] inst_q, inst_d, pc_q, pc_d, rd1_q, rd1_d, rd2_q, rd2_d;
    logic [3:0]  alu_sel_q, alu_sel_d;
    a_sel_e      a_sel_q, a_sel_d;
    b_sel_e      b_sel_q, b_sel_d;
    logic        valid_q, valid_d;
    logic [31:0] imm, rs1_v, rs2_v, b_raw;

    imm_gen u_imm_gen (.inst(inst_q), .imm(imm));

`ifdef ALU_OPERAND_STAGE_FWD_EN
    assign rs1_v = (wb_we && wb_rd != 5'd0 && wb_rd == inst_q[19:15]) ? wb_data : rd1_q;
    assign rs2_v = (wb_we && wb_rd != 5'd0 && wb_rd == inst_q[24:20]) ? wb_data : rd2_q;
`else
    logic unused_wb;
    assign unused_wb = ^{wb_we, wb_rd, wb_data};
    assign rs1_v = rd1_q;
    assign rs2_v = rd2_q;
`endif

    always_comb begin
        inst_d    = inst_q;
        pc_d      = pc_q;
        rd1_d     = rd1_q;
        rd2_d     = rd2_q;
        alu_sel_d = alu_sel_q;
        a_sel_d   = a_sel_q;
        b_sel_d   = b_sel_q;
        valid_d   = valid_q;
        if (flush) begin
            inst_d    = NOP_INST;
            pc_d      = id_pc;
            rd1_d     = '0;
            rd2_d     = '0;
            alu_sel_d = ALU_ADD;
            a_sel_d   = decode_a_sel(NOP_INST[6:0]);
            b_sel_d   = decode_b_sel(NOP_INST[6:0]);
            valid_d   = 1'b0;
        end else if (stall) begin
            // refreshing the held operands lets the instruction outlive the writeback
            rd1_d = rs1_v;
            rd2_d = rs2_v;
        end else begin
            inst_d    = id_inst;
            pc_d      = id_pc;
            rd1_d     = id_rd1;
            rd2_d     = id_rd2;
            alu_sel_d = decode_alu_sel(id_inst);
            a_sel_d   = decode_a_sel(id_inst[6:0]);
            b_sel_d   = decode_b_sel(id_inst[6:0]);
            valid_d   = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            inst_q    <= NOP_INST;
            pc_q      <= RESET_PC;
            rd1_q     <= '0;
            rd2_q     <= '0;
            alu_sel_q <= ALU_ADD;
            a_sel_q   <= decode_a_sel(NOP_INST[6:0]);
            b_sel_q   <= decode_b_sel(NOP_INST[6:0]);
            valid_q   <= 1'b0;
        end else begin
            inst_q    <= inst_d;
            pc_q      <= pc_d;
            rd1_q     <= rd1_d;
            rd2_q     <= rd2_d;
            alu_sel_q <= alu_sel_d;
            a_sel_q   <= a_sel_d;
            b_sel_q   <= b_sel_d;
            valid_q   <= valid_d;
        end
    end

    always_comb begin
        b_raw = (b_sel_q == B_SEL_RS2) ? rs2_v : imm;
        alu_a = (a_sel_q == A_SEL_PC) ? pc_q : (a_sel_q == A_SEL_ZERO) ? 32'd0 : rs1_v;
        // shifts only ever see a 5-bit amount, which also drops the SRAI funct7 bit
        alu_b = (alu_sel_q == ALU_SLL || alu_sel_q == ALU_SRL || alu_sel_q == ALU_SRA) ?
                {27'b0, b_raw[4:0]} : b_raw;
    end

    assign alu_sel     = alu_sel_q;
    assign ex_inst     = inst_q;
    assign ex_pc       = pc_q;
    assign ex_rs2_data = rs2_v;
    assign ex_valid    = valid_q;
endmodule

// File: tb/tb_alu_operand_stage.sv
// tb_alu_operand_stage: directed plus randomized checks against a behavioural model
module tb_alu_operand_stage;
    logic        clk = 1'b0;
    logic        rst, stall, flush, wb_we;
    logic [31:0] id_inst, id_pc, id_rd1, id_rd2, wb_data;
    logic [4:0]  wb_rd;
    logic [31:0] alu_a, alu_b, ex_inst, ex_pc, ex_rs2_data;
    logic [3:0]  alu_sel;
    logic        ex_valid;

    int n_checks = 0;
    int n_fail   = 0;

`ifdef ALU_OPERAND_STAGE_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic [31:0] m_inst, m_pc, m_rd1, m_rd2;
    logic        m_valid, m_known;
    logic [6:0]  opcs [9] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6f, 7'h67, 7'h37, 7'h17};

    alu_operand_stage dut (
        .clk(clk), .rst(rst), .id_inst(id_inst), .id_pc(id_pc), .id_rd1(id_rd1),
        .id_rd2(id_rd2), .stall(stall), .flush(flush), .wb_we(wb_we), .wb_rd(wb_rd),
        .wb_data(wb_data), .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
        .ex_inst(ex_inst), .ex_pc(ex_pc), .ex_rs2_data(ex_rs2_data), .ex_valid(ex_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] fwd(input logic [31:0] v, input logic [4:0] rs);
        return (FWD && wb_we && wb_rd != 0 && wb_rd == rs) ? wb_data : v;
    endfunction

    function automatic logic [31:0] exp_sel(input logic [31:0] i);
        logic [3:0] by_f3 [8] = '{0, 2, 3, 4, 5, 6, 8, 9};
        int s;
        if (i[6:0] != 7'h33 && i[6:0] != 7'h13) return 0;
        s = by_f3[i[14:12]];
        if (i[14:12] == 0 && i[6:0] == 7'h33 && i[30]) s = 1;
        if (i[14:12] == 5 && i[30]) s = 7;
        return 32'(s);
    endfunction

    function automatic logic [31:0] exp_imm(input logic [31:0] i);
        int v;
        case (i[6:0])
            7'h23:        v = ($signed(i) >>> 25) * 32 + int'(i[11:7]);
            7'h63:        v = ($signed(i) >>> 31) * 4096 + int'(i[7]) * 2048
                              + int'(i[30:25]) * 32 + int'(i[11:8]) * 2;
            7'h37, 7'h17: v = int'(i & 32'hffff_f000);
            7'h6f:        v = ($signed(i) >>> 31) * 1048576 + int'(i[19:12]) * 4096
                              + int'(i[20]) * 2048 + int'(i[30:21]) * 2;
            default:      v = $signed(i) >>> 20;
        endcase
        return 32'(v);
    endfunction

    task automatic check_all();
        logic [31:0] r1, r2, ea, eb;
        logic [6:0]  o;
        o  = m_inst[6:0];
        r1 = fwd(m_rd1, m_inst[19:15]);
        r2 = fwd(m_rd2, m_inst[24:20]);
        ea = (o == 7'h63 || o == 7'h6f || o == 7'h17) ? m_pc : (o == 7'h37) ? 0 : r1;
        eb = (o == 7'h33) ? r2 : exp_imm(m_inst);
        if (exp_sel(m_inst) inside {2, 6, 7}) eb = eb % 32;
        check("m_valid", 32'(ex_valid), 32'(m_valid));
        check("m_inst", ex_inst, m_inst);
        check("m_pc", ex_pc, m_pc);
        check("m_sel", 32'(alu_sel), exp_sel(m_inst));
        if (m_known) begin
            check("m_a", alu_a, ea);
            check("m_b", alu_b, eb);
            check("m_rs2", ex_rs2_data, r2);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        if (rst) begin
            m_inst = 32'h13; m_pc = 0; m_rd1 = 0; m_rd2 = 0; m_valid = 0; m_known = 1;
        end else if (flush) begin
            m_inst = 32'h13; m_pc = id_pc; m_valid = 0; m_known = 0;
        end else if (stall) begin
            m_rd1 = fwd(m_rd1, m_inst[19:15]);
            m_rd2 = fwd(m_rd2, m_inst[24:20]);
        end else begin
            m_inst = id_inst; m_pc = id_pc; m_rd1 = id_rd1; m_rd2 = id_rd2;
            m_valid = 1; m_known = 1;
        end
        #1;
        check_all();
    endtask

    initial begin
        rst = 1; stall = 0; flush = 0; wb_we = 0; wb_rd = 0; wb_data = 0;
        id_inst = 32'h402080B3; id_pc = 32'h40; id_rd1 = 10; id_rd2 = 3;
        m_known = 0;
        cycle(); cycle();
        rst = 0;
        #1;
        check("rst_valid", 32'(ex_valid), 0);
        check("rst_inst", ex_inst, 32'h13);
        check("rst_sel", 32'(alu_sel), 0);
        check("rst_pc", ex_pc, 0);
        cycle();
        check("sub_a", alu_a, 10);
        check("sub_b", alu_b, 3);
        check("sub_sel", 32'(alu_sel), 1);
        check("sub_valid", 32'(ex_valid), 1);
        id_inst = 32'h40435293; id_rd1 = 32'h8000_0000; cycle();
        check("srai_sel", 32'(alu_sel), 7);
        check("srai_b", alu_b, 4);
        id_inst = 32'h002090B3; id_rd2 = 32'h23; cycle();
        check("sll_b", alu_b, 3);
        id_inst = 32'h123450B7; cycle();
        check("lui_a", alu_a, 0);
        check("lui_b", alu_b, 32'h1234_5000);
        check("lui_sel", 32'(alu_sel), 0);
        id_inst = 32'h00000463; id_pc = 32'h1000; cycle();
        check("beq_a", alu_a, 32'h1000);
        check("beq_b", alu_b, 8);
        stall = 1;
        for (int k = 0; k < 3; k++) begin
            id_inst = $urandom; id_pc = $urandom; id_rd1 = $urandom; id_rd2 = $urandom;
            cycle();
            check("stall_inst", ex_inst, 32'h463);
            check("stall_pc", ex_pc, 32'h1000);
        end
        flush = 1; cycle();
        check("sf_valid", 32'(ex_valid), 0);
        check("sf_inst", ex_inst, 32'h13);
        stall = 0; flush = 0;
`ifdef ALU_OPERAND_STAGE_FWD_EN
        id_inst = 32'h002081B3; id_rd1 = 5; id_rd2 = 7; cycle();
        wb_we = 1; wb_rd = 1; wb_data = 32'h100; #1;
        check("fwd_a", alu_a, 32'h100);
        wb_rd = 0; #1;
        check("fwd_x0", alu_a, 5);
        wb_rd = 1; stall = 1; cycle();
        wb_we = 0; #1;
        check("fwd_hold", alu_a, 32'h100);
        stall = 0;
`endif
        for (int k = 0; k < 400; k++) begin
            id_inst = $urandom;
            id_inst[6:0] = opcs[$urandom_range(0, 8)];
            if ($urandom_range(0, 1) == 1) begin
                id_inst[19:15] = 5'($urandom_range(0, 3));
                id_inst[24:20] = 5'($urandom_range(0, 3));
            end
            id_pc = $urandom; id_rd1 = $urandom; id_rd2 = $urandom;
            stall = ($urandom_range(0, 4) == 0);
            flush = ($urandom_range(0, 9) == 0);
            rst   = ($urandom_range(0, 49) == 0);
            wb_we = 1'($urandom_range(0, 1));
            wb_rd = 5'($urandom_range(0, 3));
            wb_data = $urandom;
            cycle();
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
